// File: rtl/tetris_pkg.sv
// Shared playfield geometry, cell colours and the line_clearer state encoding.
package tetris_pkg;

  localparam int COLS    = 10;
  localparam int ROWS    = 20;
  localparam int COLOR_W = 24;
  localparam int ROW_W   = 5;

  localparam logic [COLOR_W-1:0] EMPTY_CELL   = 24'h000000;
  localparam logic [COLOR_W-1:0] COLOR_CYAN   = 24'h00FFFF;
  localparam logic [COLOR_W-1:0] COLOR_BLUE   = 24'h0000FF;
  localparam logic [COLOR_W-1:0] COLOR_ORANGE = 24'hFF8000;
  localparam logic [COLOR_W-1:0] COLOR_YELLOW = 24'hFFFF00;
  localparam logic [COLOR_W-1:0] COLOR_GREEN  = 24'h00FF00;
  localparam logic [COLOR_W-1:0] COLOR_PURPLE = 24'h800080;
  localparam logic [COLOR_W-1:0] COLOR_RED    = 24'hFF0000;

  typedef enum logic [2:0] {
    LC_IDLE  = 3'd0,
    LC_READ  = 3'd1,
    LC_EVAL  = 3'd2,
    LC_WRITE = 3'd3,
    LC_FILL  = 3'd4,
    LC_DONE  = 3'd5
  } lc_state_e;

endpackage

// File: rtl/row_is_full.sv
// Combinational check that every cell of a packed playfield row is occupied.
module row_is_full import tetris_pkg::*; #(
  parameter int COLS    = tetris_pkg::COLS,
  parameter int COLOR_W = tetris_pkg::COLOR_W
) (
  input  logic [COLS*COLOR_W-1:0] row,
  output logic                    full
);

  // AND together the "cell non-empty" flag of every column
  always_comb begin
    full = 1'b1;
    for (int i = 0; i < COLS; i++) begin
      full = full & (|row[i*COLOR_W +: COLOR_W]);
    end
  end

endmodule

// File: rtl/line_clearer.sv
// Removes full rows bottom-up by copying surviving rows down through the shared
// column-RAM row port, then zero-fills the vacated rows at the top.
module line_clearer import tetris_pkg::*; #(
  parameter int COLS    = tetris_pkg::COLS,
  parameter int ROWS    = tetris_pkg::ROWS,
  parameter int COLOR_W = tetris_pkg::COLOR_W,
  parameter int ROW_W   = tetris_pkg::ROW_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [ROW_W-1:0]        lines_cleared,
  output logic [ROW_W-1:0]        ram_row,
  input  logic [COLS*COLOR_W-1:0] ram_q,
  output logic [COLS*COLOR_W-1:0] ram_d,
  output logic [COLS-1:0]         ram_we
);

  localparam int              ROW_BITS = COLS * COLOR_W;
  localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  lc_state_e             state_q, state_d;
  logic [ROW_W-1:0]      rd_q, rd_d;
  logic [ROW_W-1:0]      wr_q, wr_d;
  logic [ROW_W-1:0]      cnt_q, cnt_d;
  logic [ROW_W-1:0]      lc_q, lc_d;
  logic [ROW_BITS-1:0]   buf_q, buf_d;
  logic                  row_full;
  logic [ROW_W-1:0]      rd_next;

  row_is_full #(.COLS(COLS), .COLOR_W(COLOR_W)) u_row_is_full (
    .row  (ram_q),
    .full (row_full)
  );

  // After finishing a row: scan upward, or zero the top rows if any were removed
  function automatic lc_state_e adv_state(input logic [ROW_W-1:0] rd,
                                          input logic [ROW_W-1:0] cnt);
    if (rd != ROW_ZERO) begin
      adv_state = LC_READ;
    end else if (cnt != ROW_ZERO) begin
      adv_state = LC_FILL;
    end else begin
      adv_state = LC_DONE;
    end
  endfunction

  // State and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LC_IDLE;
      rd_q    <= ROW_ZERO;
      wr_q    <= ROW_ZERO;
      cnt_q   <= ROW_ZERO;
      lc_q    <= ROW_ZERO;
      buf_q   <= {ROW_BITS{1'b0}};
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      lc_q    <= lc_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state and pointer update
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    rd_next = (rd_q != ROW_ZERO) ? (rd_q - ROW_ONE) : rd_q;
    case (state_q)
      LC_IDLE: begin
        if (start) begin
          rd_d    = LAST_ROW;
          wr_d    = LAST_ROW;
          cnt_d   = ROW_ZERO;
          state_d = LC_READ;
        end else begin
          state_d = LC_IDLE;
        end
      end
      LC_READ: state_d = LC_EVAL;
      LC_EVAL: begin
        buf_d = ram_q;
        if (row_full) begin
          cnt_d   = cnt_q + ROW_ONE;
          rd_d    = rd_next;
          state_d = adv_state(rd_q, cnt_q + ROW_ONE);
        end else if (wr_q != rd_q) begin
          state_d = LC_WRITE;
        end else begin
          // Nothing removed below yet: the row is already in place
          wr_d    = wr_q - ROW_ONE;
          rd_d    = rd_next;
          state_d = adv_state(rd_q, cnt_q);
        end
      end
      LC_WRITE: begin
        wr_d    = wr_q - ROW_ONE;
        rd_d    = rd_next;
        state_d = adv_state(rd_q, cnt_q);
      end
      LC_FILL: begin
        if (wr_q == ROW_ZERO) begin
          state_d = LC_DONE;
        end else begin
          wr_d = wr_q - ROW_ONE;
        end
      end
      LC_DONE: state_d = LC_IDLE;
      default: state_d = LC_IDLE;
    endcase
    lc_d = (state_d == LC_DONE) ? cnt_d : lc_q;
  end

  // Moore decode of status and RAM port from the registers
  always_comb begin
    busy          = (state_q != LC_IDLE);
    done          = (state_q == LC_DONE);
    lines_cleared = lc_q;
    ram_row       = ROW_ZERO;
    ram_d         = {ROW_BITS{1'b0}};
    ram_we        = {COLS{1'b0}};
    case (state_q)
      LC_READ, LC_EVAL: ram_row = rd_q;
      LC_WRITE: begin
        ram_row = wr_q;
        ram_d   = buf_q;
        ram_we  = {COLS{1'b1}};
      end
      LC_FILL: begin
        ram_row = wr_q;
        ram_we  = {COLS{1'b1}};
      end
      default: ram_row = ROW_ZERO;
    endcase
  end

endmodule

// File: tb/tb_line_clearer.sv
// Directed bench for line_clearer with a behavioural 1-cycle-latency column RAM.
module tb_line_clearer;

  localparam int COLS    = 10;
  localparam int ROWS    = 20;
  localparam int COLOR_W = 24;
  localparam int ROW_W   = 5;
  localparam int RB      = COLS * COLOR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              busy, done;
  logic [ROW_W-1:0]  lines_cleared, ram_row;
  logic [RB-1:0]     ram_q = '0;
  logic [RB-1:0]     ram_d;
  logic [COLS-1:0]   ram_we;

  logic [RB-1:0] mem   [ROWS];
  logic [RB-1:0] img   [ROWS];
  logic [RB-1:0] exp_f [ROWS];
  logic          load = 1'b0;

  int checks = 0;
  int errors = 0;

  line_clearer #(.COLS(COLS), .ROWS(ROWS), .COLOR_W(COLOR_W), .ROW_W(ROW_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .lines_cleared(lines_cleared), .ram_row(ram_row), .ram_q(ram_q),
    .ram_d(ram_d), .ram_we(ram_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load) begin
      for (int r = 0; r < ROWS; r++) mem[r] <= img[r];
    end else if (int'(ram_row) < ROWS) begin
      for (int c = 0; c < COLS; c++)
        if (ram_we[c]) mem[ram_row][c*COLOR_W +: COLOR_W] <= ram_d[c*COLOR_W +: COLOR_W];
    end
    ram_q <= (int'(ram_row) < ROWS) ? mem[ram_row] : '0;
  end

  function automatic logic [RB-1:0] pat_row(input int r);
    logic [RB-1:0] v;
    v = '0;
    for (int c = 0; c < COLS - 1; c++) v[c*COLOR_W +: COLOR_W] = COLOR_W'((r + 1) * 256 + c + 1);
    return v;
  endfunction

  function automatic logic [RB-1:0] full_row(input logic [COLOR_W-1:0] color);
    logic [RB-1:0] v;
    for (int c = 0; c < COLS; c++) v[c*COLOR_W +: COLOR_W] = color;
    return v;
  endfunction

  function automatic int field_diff();
    int n;
    n = 0;
    for (int r = 0; r < ROWS; r++) if (mem[r] !== exp_f[r]) n++;
    return n;
  endfunction

  task automatic load_field();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic run_pass(input int restart_at, output int done_cyc, output int we_cnt,
                          output logic busy1);
    int k;
    done_cyc = -1; we_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; k = 0; busy1 = busy;
    while (done_cyc < 0 && k < 300) begin
      if (ram_we !== '0) we_cnt++;
      if (done === 1'b1) done_cyc = k + 1;
      start = (k + 1 == restart_at);
      @(negedge clk); k++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (lines_cleared !== 5'd0) begin errors++; $display("FAIL reset_lines: got %0d expected 0", lines_cleared); end
    checks++; if (ram_row !== 5'd0) begin errors++; $display("FAIL reset_row: got %0d expected 0", ram_row); end
    checks++; if (ram_d !== '0) begin errors++; $display("FAIL reset_d: got %h expected 0", ram_d); end
    checks++; if (ram_we !== 10'd0) begin errors++; $display("FAIL reset_we: got %b expected 0", ram_we); end
    rst = 1'b0;
  endtask

  task automatic test_empty();
    int dc, wc; logic b1;
    for (int r = 0; r < ROWS; r++) begin img[r] = '0; exp_f[r] = '0; end
    load_field();
    run_pass(-1, dc, wc, b1);
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL empty_busy_rise: got %b expected 1", b1); end
    checks++; if (dc !== 41) begin errors++; $display("FAIL empty_done_cycle: got %0d expected 41", dc); end
    checks++; if (lines_cleared !== 5'd0) begin errors++; $display("FAIL empty_lines: got %0d expected 0", lines_cleared); end
    checks++; if (wc !== 0) begin errors++; $display("FAIL empty_writes: got %0d expected 0", wc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy_fall: got %b expected 0", busy); end
  endtask

  task automatic setup_one_row();
    for (int r = 0; r < ROWS - 1; r++) img[r] = pat_row(r);
    img[ROWS-1] = full_row(24'h00FF00);
    exp_f[0] = '0;
    for (int r = 1; r < ROWS; r++) exp_f[r] = img[r-1];
    load_field();
  endtask

  task automatic test_one_row(input int restart_at, input string tag);
    int dc, wc, nd; logic b1;
    setup_one_row();
    run_pass(restart_at, dc, wc, b1);
    nd = field_diff();
    checks++; if (dc !== 61) begin errors++; $display("FAIL %s_done_cycle: got %0d expected 61", tag, dc); end
    checks++; if (lines_cleared !== 5'd1) begin errors++; $display("FAIL %s_lines: got %0d expected 1", tag, lines_cleared); end
    checks++; if (nd !== 0) begin errors++; $display("FAIL %s_field: %0d rows differ, expected 0", tag, nd); end
    checks++; if (wc !== 20) begin errors++; $display("FAIL %s_writes: got %0d expected 20", tag, wc); end
  endtask

  task automatic test_four_rows();
    int dc, wc, nd; logic b1;
    for (int r = 0; r < ROWS; r++) begin img[r] = '0; exp_f[r] = '0; end
    for (int r = 16; r < ROWS; r++) img[r] = full_row(24'h0000FF);
    img[15][COLOR_W-1:0] = 24'hFF0000;
    exp_f[19] = img[15];
    load_field();
    run_pass(-1, dc, wc, b1);
    nd = field_diff();
    checks++; if (lines_cleared !== 5'd4) begin errors++; $display("FAIL four_lines: got %0d expected 4", lines_cleared); end
    checks++; if (nd !== 0) begin errors++; $display("FAIL four_field: %0d rows differ, expected 0", nd); end
    checks++; if (dc !== 61) begin errors++; $display("FAIL four_done_cycle: got %0d expected 61", dc); end
  endtask

  task automatic test_split_rows();
    int dc, wc, nd; logic b1;
    for (int r = 0; r < ROWS; r++) img[r] = pat_row(r);
    img[17] = full_row(24'hFFFF00);
    img[19] = full_row(24'h800080);
    exp_f[0] = '0; exp_f[1] = '0;
    for (int r = 2; r <= 18; r++) exp_f[r] = img[r-2];
    exp_f[19] = img[18];
    load_field();
    run_pass(-1, dc, wc, b1);
    nd = field_diff();
    checks++; if (lines_cleared !== 5'd2) begin errors++; $display("FAIL split_lines: got %0d expected 2", lines_cleared); end
    checks++; if (nd !== 0) begin errors++; $display("FAIL split_field: %0d rows differ, expected 0", nd); end
    checks++; if (mem[19] !== img[18]) begin errors++; $display("FAIL split_row19: got %h expected %h", mem[19], img[18]); end
    checks++; if (wc !== 20) begin errors++; $display("FAIL split_writes: got %0d expected 20", wc); end
  endtask

  task automatic test_mid_reset();
    int dc, wc, nd; logic b1;
    setup_one_row();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (ram_we !== 10'd0) begin errors++; $display("FAIL midrst_we: got %b expected 0", ram_we); end
    checks++; if (lines_cleared !== 5'd0) begin errors++; $display("FAIL midrst_lines: got %0d expected 0", lines_cleared); end
    rst = 1'b0;
    setup_one_row();
    run_pass(-1, dc, wc, b1);
    nd = field_diff();
    checks++; if (dc !== 61) begin errors++; $display("FAIL after_rst_done_cycle: got %0d expected 61", dc); end
    checks++; if (lines_cleared !== 5'd1) begin errors++; $display("FAIL after_rst_lines: got %0d expected 1", lines_cleared); end
    checks++; if (nd !== 0) begin errors++; $display("FAIL after_rst_field: %0d rows differ, expected 0", nd); end
  endtask

  task automatic test_all_full();
    int dc, wc, nd; logic b1;
    for (int r = 0; r < ROWS; r++) begin img[r] = full_row(24'h00FFFF); exp_f[r] = '0; end
    load_field();
    run_pass(-1, dc, wc, b1);
    nd = field_diff();
    checks++; if (lines_cleared !== 5'd20) begin errors++; $display("FAIL all_lines: got %0d expected 20", lines_cleared); end
    checks++; if (wc !== 20) begin errors++; $display("FAIL all_fill_writes: got %0d expected 20", wc); end
    checks++; if (nd !== 0) begin errors++; $display("FAIL all_field: %0d rows differ, expected 0", nd); end
    checks++; if (dc !== 61) begin errors++; $display("FAIL all_done_cycle: got %0d expected 61", dc); end
  endtask

  initial begin
    for (int r = 0; r < ROWS; r++) begin img[r] = '0; exp_f[r] = '0; end
    test_reset();
    test_empty();
    test_one_row(-1, "one_row");
    test_four_rows();
    test_split_rows();
    test_one_row(5, "restart_ignored");
    test_mid_reset();
    test_all_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
